sr_deser: RTL and testbench
===========================

# sr_deser

Serial-to-parallel collector sitting directly downstream of the shift register stage. It samples the register's serial output on each qualified clock, assembles `WIDTH`-bit words, and queues them in a small FIFO. The FIFO is drained by the parallel consumer over a valid/ready handshake. Overruns are flagged, not stalled, because the serial side has no backpressure.

## Interface
Parameters:
- `WIDTH`, 8, bits per assembled word (≥2)
- `DEPTH`, 4, FIFO entries (power of 2, ≥2)
- `MSB_FIRST`, 1, 1: first serial bit lands in bit `WIDTH-1`; 0: first bit lands in bit 0

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low; sampled only on `clk` rising edge
- `ser_in`  in  1  serial bit from shift register `data_out`
- `ser_vld`  in  1  `ser_in` is a valid bit this cycle (the shift enable, aligned to `data_out`)
- `flush`  in  1  discard partially assembled word
- `m_data`  out  `WIDTH`  FIFO head word
- `m_valid`  out  1  FIFO non-empty
- `m_ready`  in  1  consumer accepts head this cycle
- `fill`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..`DEPTH`
- `overflow`  out  1  sticky; a completed word was dropped
- `clr_ovf`  in  1  clears `overflow`

## Operation
- Reset (`reset`=0 at edge): bit counter=0, accumulator=0, FIFO pointers=0, `fill`=0, `m_valid`=0, `m_data`=0, `overflow`=0. Reset overrides all other inputs and discards any partial word and FIFO contents.
- Accumulate: on each edge with `ser_vld`=1 and `flush`=0:
  - Insert `ser_in` into the accumulator at the position given by the counter, respecting `MSB_FIRST`.
  - Increment the counter.
- Word complete: the bit taken while counter=`WIDTH-1` completes a word. That word (accumulator plus current bit) is pushed to the FIFO on the same edge, and the counter wraps to 0.
- Push acceptance: a push is accepted if `fill`<`DEPTH`, or if `fill`=`DEPTH` and a pop occurs on the same edge.
  - Otherwise the word is dropped, `overflow` is set, and the counter still wraps to 0.
- Pop: occurs on an edge where `m_valid`=1 and `m_ready`=1. The read pointer advances.
- `fill` update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- `m_data`: equals the FIFO head when `fill`>0, else 0. It is held stable while `m_valid`=1 and `m_ready`=0.
- `flush`=1: counter←0 and accumulator←0. A `ser_vld` bit in the same cycle is discarded (flush wins). The FIFO and pops are unaffected.
- `overflow`: set wins over `clr_ovf` in the same cycle; otherwise `clr_ovf`=1 clears it.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Empty and full are derived from `fill`, never from pointer equality alone.
- Gaps with `ser_vld`=0 are allowed anywhere mid-word. The partial word is held indefinitely.

## Timing
- Latency: the last bit of a word is sampled on edge N. `m_valid`=1 and `m_data`=word are visible after edge N, i.e. usable at edge N+1.
- Throughput: one bit per cycle sustained. With `m_ready` held 1, the FIFO never exceeds 1 entry.
- The handshake completes on any edge with `m_valid`&&`m_ready`. `m_ready` may be high while `m_valid`=0, with no effect.
- All outputs are registered or are decoded directly from registered state. There is no combinational path from `ser_in` or `ser_vld` to any output.
- `m_valid` does not depend combinationally on `m_ready`.

## Test plan
- Reset check:
  - Stimulus: hold `reset`=0 for 2 cycles mid-word, with 3 bits already taken.
  - Required: `m_valid`=0, `fill`=0, `overflow`=0, `m_data`=0.
  - Then shift 8 bits 1,0,1,0,0,1,0,1: exactly one word 0xA5, so the stale partial bits are gone.
- Bit order:
  - `WIDTH`=8, `MSB_FIRST`=1, serial 1,0,1,0,0,1,0,1 -> `m_data`=0xA5, `m_valid` high one cycle after the 8th bit edge.
  - Same with `MSB_FIRST`=0 -> 0xA5 as well (palindrome). Then serial 1,1,0,0,0,0,0,0 -> 0x03 (LSB-first) vs 0xC0 (MSB-first).
- Backpressure and overflow:
  - `m_ready`=0, push 5 words 0x01..0x05 with `DEPTH`=4 -> `fill`=4, `overflow`=1 after the 5th word, 0x05 dropped.
  - Drain -> 0x01,0x02,0x03,0x04 in order; `m_data` stable while stalled.
- Full with simultaneous pop:
  - `fill`=4, 5th word completes on the same edge as a pop -> `fill` stays 4, `overflow` stays 0, 5th word is readable last.
- Flush and gaps:
  - 5 bits, then `flush` with `ser_vld`=1 -> that bit is discarded.
  - Then 8 bits with random `ser_vld` gaps -> exactly one word equal to those 8 bits.
  - FIFO contents present before the flush are unaffected.
- Overflow clear race:
  - `clr_ovf`=1 on the same edge as a drop -> `overflow`=1.
  - `clr_ovf` on the next cycle alone -> `overflow`=0.

Source files
------------

// File: rtl/sr_deser.sv
// rtl/sr_deser.sv - serial-to-parallel word collector with a small output FIFO and sticky overflow
module sr_deser #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ser_in,
    input  logic                     ser_vld,
    input  logic                     flush,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [PW:0]   FILL_MAX = (PW + 1)'(DEPTH);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             take;
    logic             last;
    logic             pop;
    logic             push;
    logic             drop;

    // word is the accumulator with the current bit already inserted, so a
    // completing bit can be pushed on the same edge it is sampled.
    always_comb begin
        pos        = (MSB_FIRST != 0) ? (CNT_LAST - cnt) : cnt;
        word       = acc;
        word[pos]  = ser_in;
    end

    assign take = ser_vld & ~flush;
    assign last = take & (cnt == CNT_LAST);
    assign pop  = m_valid & m_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push = last & ((fill != FILL_MAX) | pop);
    assign drop = last & ~push;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush || last) begin
                cnt <= '0;
                acc <= '0;
            end else if (take) begin
                cnt <= cnt + CW'(1);
                acc <= word;
            end

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   fill <= fill + (PW + 1)'(1);
                2'b01:   fill <= fill - (PW + 1)'(1);
                default: fill <= fill;
            endcase

            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // Storage needs no reset: the head is masked by fill below.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    assign m_valid = (fill != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sr_deser.sv
// tb/tb_sr_deser.sv - directed self-checking bench for sr_deser (MSB-first and LSB-first instances)
module tb_sr_deser;

    logic       clk;
    logic       reset;
    logic       ser_in;
    logic       ser_vld;
    logic       flush;
    logic       m_ready;
    logic       clr_ovf;
    logic [7:0] m_data;
    logic       m_valid;
    logic [2:0] fill;
    logic       overflow;
    logic [7:0] l_data;
    logic       l_valid;
    logic [2:0] l_fill;
    logic       l_overflow;

    int nchecks = 0;
    int nerr    = 0;

    sr_deser #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_vld(ser_vld), .flush(flush),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fill(fill),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    sr_deser #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_vld(ser_vld), .flush(flush),
        .m_data(l_data), .m_valid(l_valid), .m_ready(m_ready), .fill(l_fill),
        .overflow(l_overflow), .clr_ovf(clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus helpers: entered and left at a falling edge, one rising edge consumed.
    task automatic shift_bit(input logic b);
        ser_in  = b;
        ser_vld = 1'b1;
        @(negedge clk);
        ser_vld = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        nchecks++;
        if ({m_valid, fill, overflow, m_data} !== 13'd0) begin
            nerr++;
            $display("FAIL reset_init: got valid=%b fill=%0d ovf=%b data=%h, exp all 0", m_valid, fill, overflow, m_data);
        end
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        nchecks++;
        if (m_valid !== 1'b0 || fill !== 3'd0) begin
            nerr++;
            $display("FAIL ready_while_empty: got valid=%b fill=%0d, exp 0 0", m_valid, fill);
        end
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        nchecks++;
        if ({m_valid, fill, overflow, m_data} !== 13'd0) begin
            nerr++;
            $display("FAIL reset_midword: got valid=%b fill=%0d ovf=%b data=%h, exp all 0", m_valid, fill, overflow, m_data);
        end
        for (int i = 0; i < 7; i++) shift_bit((8'hA5 >> (7 - i)) & 1'b1);
        nchecks++;
        if (m_valid !== 1'b0) begin
            nerr++;
            $display("FAIL early_valid: got m_valid=%b after 7 bits, exp 0", m_valid);
        end
        shift_bit(1'b1);
        nchecks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || fill !== 3'd1) begin
            nerr++;
            $display("FAIL post_reset_word: got valid=%b data=%h fill=%0d, exp 1 a5 1", m_valid, m_data, fill);
        end
        nchecks++;
        if (l_data !== 8'hA5 || l_fill !== 3'd1) begin
            nerr++;
            $display("FAIL lsb_palindrome: got data=%h fill=%0d, exp a5 1", l_data, l_fill);
        end
        pop_one();
        nchecks++;
        if (fill !== 3'd0 || l_fill !== 3'd0) begin
            nerr++;
            $display("FAIL reset_drain: got fill=%0d/%0d, exp 0/0", fill, l_fill);
        end
    endtask

    task automatic test_bit_order();
        shift_byte(8'b1100_0000);
        nchecks++;
        if (m_data !== 8'hC0) begin
            nerr++;
            $display("FAIL order_msb: got %h exp c0", m_data);
        end
        nchecks++;
        if (l_data !== 8'h03) begin
            nerr++;
            $display("FAIL order_lsb: got %h exp 03", l_data);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d;
        m_ready = 1'b0;
        for (int w = 1; w <= 4; w++) shift_byte(8'(w));
        nchecks++;
        if (fill !== 3'd4 || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_full: got fill=%0d ovf=%b, exp 4 0", fill, overflow);
        end
        shift_byte(8'h05);
        nchecks++;
        if (fill !== 3'd4 || overflow !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_drop: got fill=%0d ovf=%b, exp 4 1", fill, overflow);
        end
        idle(3);
        nchecks++;
        if (m_data !== 8'h01) begin
            nerr++;
            $display("FAIL ovf_stall_stable: got %h exp 01", m_data);
        end
        for (int w = 1; w <= 4; w++) begin
            exp_d = 8'(w);
            nchecks++;
            if (m_data !== exp_d) begin
                nerr++;
                $display("FAIL ovf_drain: got %h exp %h", m_data, exp_d);
            end
            pop_one();
        end
        nchecks++;
        if (fill !== 3'd0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
            nerr++;
            $display("FAIL ovf_empty: got fill=%0d valid=%b data=%h, exp 0 0 00", fill, m_valid, m_data);
        end
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_d;
        for (int w = 1; w <= 4; w++) shift_byte(8'h10 + 8'(w));
        for (int i = 7; i >= 1; i--) shift_bit((8'h15 >> i) & 1'b1);
        ser_in  = 1'b1;
        ser_vld = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        ser_vld = 1'b0;
        m_ready = 1'b0;
        nchecks++;
        if (fill !== 3'd4 || overflow !== 1'b0 || m_data !== 8'h12) begin
            nerr++;
            $display("FAIL full_pop: got fill=%0d ovf=%b head=%h, exp 4 0 12", fill, overflow, m_data);
        end
        for (int w = 2; w <= 5; w++) begin
            exp_d = 8'h10 + 8'(w);
            nchecks++;
            if (m_data !== exp_d) begin
                nerr++;
                $display("FAIL full_pop_drain: got %h exp %h", m_data, exp_d);
            end
            pop_one();
        end
    endtask

    task automatic test_flush_gaps();
        logic [7:0] v;
        shift_byte(8'h3C);
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        ser_in  = 1'b1;
        ser_vld = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        ser_vld = 1'b0;
        flush   = 1'b0;
        v = 8'h96;
        for (int i = 7; i >= 0; i--) begin
            shift_bit(v[i]);
            idle($urandom_range(0, 2));
        end
        nchecks++;
        if (fill !== 3'd2 || m_data !== 8'h3C) begin
            nerr++;
            $display("FAIL flush_keep_fifo: got fill=%0d head=%h, exp 2 3c", fill, m_data);
        end
        pop_one();
        nchecks++;
        if (fill !== 3'd1 || m_data !== 8'h96) begin
            nerr++;
            $display("FAIL flush_gap_word: got fill=%0d data=%h, exp 1 96", fill, m_data);
        end
        nchecks++;
        if (l_fill !== 3'd1 || l_data !== 8'h69) begin
            nerr++;
            $display("FAIL flush_gap_lsb: got fill=%0d data=%h, exp 1 69", l_fill, l_data);
        end
        pop_one();
    endtask

    task automatic test_ovf_race();
        nchecks++;
        if (overflow !== 1'b0) begin
            nerr++;
            $display("FAIL race_pre: got ovf=%b exp 0", overflow);
        end
        for (int w = 0; w < 4; w++) shift_byte(8'h21);
        for (int i = 0; i < 7; i++) shift_bit(1'b0);
        ser_in  = 1'b1;
        ser_vld = 1'b1;
        clr_ovf = 1'b1;
        @(negedge clk);
        ser_vld = 1'b0;
        nchecks++;
        if (overflow !== 1'b1 || fill !== 3'd4) begin
            nerr++;
            $display("FAIL race_set_wins: got ovf=%b fill=%0d, exp 1 4", overflow, fill);
        end
        @(negedge clk);
        clr_ovf = 1'b0;
        nchecks++;
        if (overflow !== 1'b0) begin
            nerr++;
            $display("FAIL race_clear: got ovf=%b exp 0", overflow);
        end
        m_ready = 1'b1;
        idle(4);
        m_ready = 1'b0;
        nchecks++;
        if (fill !== 3'd0) begin
            nerr++;
            $display("FAIL race_drain: got fill=%0d exp 0", fill);
        end
    endtask

    initial begin
        ser_in  = 1'b0;
        ser_vld = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        test_reset();
        test_bit_order();
        test_overflow();
        test_full_pop();
        test_flush_gaps();
        test_ovf_race();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
